// File: rtl/ysyx_22041207_hazard_ctrl_pkg.sv
// ysyx_22041207_hazard_ctrl_pkg: shared FSM state encoding and register constants for the hazard controller
package ysyx_22041207_hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/ysyx_22041207_hazard_ctrl_if.sv
// ysyx_22041207_hazard_ctrl_if: decoder/pipeline-side hazard signals; master drives stage info, slave returns stall/flush
interface ysyx_22041207_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] id_rs1addr;
  logic [4:0] id_rs2addr;
  logic id_use_rs1;
  logic id_use_rs2;
  logic [4:0] ex_rwaddr;
  logic ex_writeRD;
  logic ex_memoryReadWen;
  logic ex_redirect;
  logic mem_req;
  logic mem_ack;
  logic pc_stall;
  logic ifid_bubble;
  logic ifid_flush;
  logic idex_bubble;
  logic idex_flush;
  logic exmem_bubble;
  logic timeout_o;
  logic [CNT_W-1:0] stall_cycles_o;
  logic [CNT_W-1:0] flush_count_o;
  modport master (
    output id_rs1addr, id_rs2addr, id_use_rs1, id_use_rs2, ex_rwaddr, ex_writeRD,
           ex_memoryReadWen, ex_redirect, mem_req, mem_ack,
    input  pc_stall, ifid_bubble, ifid_flush, idex_bubble, idex_flush, exmem_bubble,
           timeout_o, stall_cycles_o, flush_count_o
  );
  modport slave (
    input  id_rs1addr, id_rs2addr, id_use_rs1, id_use_rs2, ex_rwaddr, ex_writeRD,
           ex_memoryReadWen, ex_redirect, mem_req, mem_ack,
    output pc_stall, ifid_bubble, ifid_flush, idex_bubble, idex_flush, exmem_bubble,
           timeout_o, stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/ysyx_22041207_sat_counter.sv
// ysyx_22041207_sat_counter: enabled up-counter that sticks at all-ones instead of wrapping
module ysyx_22041207_sat_counter #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/ysyx_22041207_hazard_ctrl.sv
// ysyx_22041207_hazard_ctrl: stall/flush controller with memory-hang watchdog;
// perf counters built only when YSYX_22041207_HAZARD_PERF_EN is defined
module ysyx_22041207_hazard_ctrl
  import ysyx_22041207_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic rst_n,
  ysyx_22041207_hazard_ctrl_if.slave hz
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  state_t state, state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic freeze, redirect, load_use, rs_hit;
  always_comb begin
    rs_hit = (hz.id_use_rs1 && hz.id_rs1addr == hz.ex_rwaddr) ||
             (hz.id_use_rs2 && hz.id_rs2addr == hz.ex_rwaddr);
    freeze = state == TRAP || (state == RUN && hz.mem_req && !hz.mem_ack) ||
             (state == MEM_WAIT && !hz.mem_ack);
    redirect = hz.ex_redirect && !freeze;
    load_use = hz.ex_memoryReadWen && hz.ex_writeRD && hz.ex_rwaddr != REG_ZERO &&
               rs_hit && !freeze && !hz.ex_redirect;
    // an ack in the last allowed wait cycle still beats the watchdog
    state_nxt = state == RUN      ? ((hz.mem_req && !hz.mem_ack) ? MEM_WAIT : RUN) :
                state == MEM_WAIT ? (hz.mem_ack ? RUN :
                                     wait_cnt == WC_W'(MEM_TIMEOUT - 1) ? TRAP : MEM_WAIT) :
                state == TRAP     ? TRAP : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= state == MEM_WAIT ? wait_cnt + WC_W'(1) : '0;
    end
  assign hz.pc_stall     = freeze | load_use;
  assign hz.ifid_bubble  = freeze | load_use;
  assign hz.ifid_flush   = redirect;
  assign hz.idex_bubble  = freeze;
  assign hz.idex_flush   = redirect | load_use;
  assign hz.exmem_bubble = freeze;
  assign hz.timeout_o    = state == TRAP;
`ifdef YSYX_22041207_HAZARD_PERF_EN
  ysyx_22041207_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .en(hz.pc_stall), .cnt(hz.stall_cycles_o)
  );
  ysyx_22041207_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .en(hz.idex_flush), .cnt(hz.flush_count_o)
  );
`else
  assign hz.stall_cycles_o = '0;
  assign hz.flush_count_o  = '0;
`endif
endmodule

// File: tb/tb_ysyx_22041207_hazard_ctrl.sv
// tb_ysyx_22041207_hazard_ctrl: table vectors plus multi-cycle sequences, scoreboard-checked at negedge
module tb_ysyx_22041207_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ysyx_22041207_hazard_ctrl_if #(.CNT_W(4)) hz();
  ysyx_22041207_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
  typedef struct {
    logic [4:0] rs1, rs2, rw;
    logic u1, u2, wr, ld, rd, req, ack;
  } in_t;
  typedef struct {
    in_t i;
    logic [6:0] e;
    string n;
  } vec_t;
  typedef struct {
    string n;
    logic [6:0] e;
  } sb_t;
  // expected output vectors: {pc_stall, ifid_bubble, ifid_flush, idex_bubble, idex_flush, exmem_bubble, timeout_o}
  localparam logic [6:0] Z  = 7'b0000000;
  localparam logic [6:0] LU = 7'b1100100;
  localparam logic [6:0] RD = 7'b0010100;
  localparam logic [6:0] FZ = 7'b1101010;
  localparam logic [6:0] TR = 7'b1101011;
  int checks = 0;
  int errors = 0;
  sb_t q[$];
  vec_t tbl[12];
  function automatic in_t mk(input logic [4:0] rs1, rs2, rw,
                             input logic u1, u2, wr, ld, rd, req, ack);
    in_t x;
    x.rs1 = rs1; x.rs2 = rs2; x.rw = rw; x.u1 = u1; x.u2 = u2;
    x.wr = wr; x.ld = ld; x.rd = rd; x.req = req; x.ack = ack;
    return x;
  endfunction
  function automatic int cexp(input int v);
`ifdef YSYX_22041207_HAZARD_PERF_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction
  function automatic logic [6:0] outs();
    return {hz.pc_stall, hz.ifid_bubble, hz.ifid_flush, hz.idex_bubble,
            hz.idex_flush, hz.exmem_bubble, hz.timeout_o};
  endfunction
  task automatic drive(input in_t x);
    hz.id_rs1addr = x.rs1; hz.id_rs2addr = x.rs2; hz.ex_rwaddr = x.rw;
    hz.id_use_rs1 = x.u1; hz.id_use_rs2 = x.u2; hz.ex_writeRD = x.wr;
    hz.ex_memoryReadWen = x.ld; hz.ex_redirect = x.rd;
    hz.mem_req = x.req; hz.mem_ack = x.ack;
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic step(input in_t x, input logic [6:0] e, input string n);
    sb_t s;
    @(posedge clk);
    #1;
    drive(x);
    s.n = n;
    s.e = e;
    q.push_back(s);
    @(negedge clk);
    s = q.pop_front();
    chk(s.n, 32'(outs()), 32'(s.e));
  endtask
  task automatic cnt_chk(input string n, input int s, input int f);
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk({n, " stall_cycles"}, 32'(hz.stall_cycles_o), 32'(cexp(s)));
    chk({n, " flush_count"}, 32'(hz.flush_count_o), 32'(cexp(f)));
  endtask
  task automatic do_reset(input string n);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 rst_n = 1'b0;
    #1;
    chk({n, " reset outs"}, 32'(outs()), 32'(Z));
    chk({n, " reset stall_cycles"}, 32'(hz.stall_cycles_o), 32'd0);
    chk({n, " reset flush_count"}, 32'(hz.flush_count_o), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL global timeout got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    in_t idle, lu5, req, reqack;
    int ns, nf;
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu5    = mk(5, 0, 5, 1, 0, 1, 1, 0, 0, 0);
    req    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    reqack = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), Z,  "idle"};
    tbl[1]  = '{mk(5, 0, 5, 1, 0, 1, 1, 0, 0, 0), LU, "lu rs1"};
    tbl[2]  = '{mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 0), Z,  "lu rd0"};
    tbl[3]  = '{mk(0, 5, 5, 0, 1, 1, 1, 0, 0, 0), LU, "lu rs2"};
    tbl[4]  = '{mk(5, 0, 5, 0, 0, 1, 1, 0, 0, 0), Z,  "lu unused rs"};
    tbl[5]  = '{mk(5, 0, 5, 1, 0, 1, 0, 0, 0, 0), Z,  "non-load"};
    tbl[6]  = '{mk(5, 0, 5, 1, 0, 0, 1, 0, 0, 0), Z,  "load no wr"};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), RD, "redirect"};
    tbl[8]  = '{mk(5, 0, 5, 1, 0, 1, 1, 1, 0, 0), RD, "redirect over lu"};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), Z,  "same-cycle ack"};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), RD, "ack+redirect"};
    tbl[11] = '{mk(6, 0, 5, 1, 0, 1, 1, 0, 0, 0), Z,  "rs mismatch"};
    drive(idle);
    do_reset("initial");
    ns = 0;
    nf = 0;
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].i, tbl[k].e, tbl[k].n);
      ns += int'(tbl[k].e[6]);
      nf += int'(tbl[k].e[2]);
    end
    cnt_chk("table", ns, nf);
    do_reset("lu seq");
    step(lu5, LU, "lu one cycle");
    step(mk(5, 0, 0, 1, 0, 0, 0, 0, 0, 0), Z, "lu nop follows");
    cnt_chk("lu seq", 1, 1);
    do_reset("memwait");
    for (int k = 0; k < 4; k++) step(req, FZ, "memwait freeze");
    step(reqack, Z, "memwait ack unfrozen");
    step(idle, Z, "memwait back in run");
    step(reqack, Z, "memwait same-cycle ack");
    step(idle, Z, "memwait same-cycle stays run");
    cnt_chk("memwait", 4, 0);
    do_reset("redir freeze");
    for (int k = 0; k < 3; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), FZ, "redir held frozen");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), RD, "redir on ack");
    step(idle, Z, "redir after");
    cnt_chk("redir freeze", 3, 1);
    do_reset("watchdog");
    for (int k = 0; k < 9; k++) step(req, FZ, "watchdog wait");
    step(req, TR, "watchdog trap");
    step(reqack, TR, "watchdog ack ignored");
    step(idle, TR, "watchdog trap held");
    do_reset("reset in trap");
    step(idle, Z, "run after trap reset");
    for (int k = 0; k < 8; k++) step(req, FZ, "late ack wait");
    step(reqack, Z, "late ack beats watchdog");
    step(idle, Z, "late ack back in run");
    step(req, FZ, "reset mid-wait enter");
    step(req, FZ, "reset mid-wait hold");
    do_reset("reset in mem_wait");
    step(idle, Z, "run after wait reset");
    do_reset("saturate");
    for (int k = 0; k < 20; k++) step(lu5, LU, "saturate lu");
    cnt_chk("saturate", 15, 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
